// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state type, widths and helpers for the fetch unit
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;
  localparam int PC_INC  = 4;
  localparam int ENTRY_W = ADDR_W + INSTR_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2,
    FULL    = 2'd3
  } fetch_state_e;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - instruction buffer holding {pc, instr} entries with flush
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = ENTRY_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             Reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // Flush dominates; push/pop are also guarded here so the count can never over/underflow.
  always_comb begin
    do_push  = push && !flush && (count_q != CNT_W'(DEPTH));
    do_pop   = pop && !flush && (count_q != '0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];
  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch FSM feeding a decode-side buffer
// Optional FETCH_PERF_EN adds perf_fetch_cnt / perf_stall_cnt counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                DEPTH      = 2,
  parameter logic [ADDR_W-1:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic               clock,
  input  logic               Reset,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  input  logic               if_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_stall_cnt
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]  pend_pc_q, pend_pc_d;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               push, pop;
  logic               fifo_empty, fifo_full;
  logic [CNT_W-1:0]   fifo_count, count_after;
  logic [ENTRY_W-1:0] head;

  // A redirect flushes the buffer, so any pop requested in that cycle is void.
  assign redirect_pc = word_align(redirect_addr);
  assign pop         = if_valid && if_ready && !redirect_valid;
  assign push        = (state_q == FETCH) && imem_ack && !redirect_valid && !fifo_full;
  assign count_after = fifo_count + CNT_W'(push) - CNT_W'(pop);

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_ADDR;
      pend_pc_q  <= RESET_ADDR;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pend_pc_q  <= pend_pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pend_pc_d  = pend_pc_q;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (imem_ack && redirect_valid) begin
          fetch_pc_d = redirect_pc;
        end else if (redirect_valid) begin
          pend_pc_d = redirect_pc;
          state_d   = DISCARD;
        end else if (push) begin
          fetch_pc_d = fetch_pc_q + ADDR_W'(PC_INC);
          if (count_after == CNT_W'(DEPTH)) begin
            state_d = FULL;
          end
        end
      end
      // The in-flight request must complete before the new target can be issued.
      DISCARD: begin
        if (redirect_valid) begin
          pend_pc_d = redirect_pc;
        end
        if (imem_ack) begin
          fetch_pc_d = redirect_valid ? redirect_pc : pend_pc_q;
          state_d    = FETCH;
        end
      end
      FULL: begin
        if (redirect_valid) begin
          fetch_pc_d = redirect_pc;
          state_d    = FETCH;
        end else if (pop) begin
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    imem_req  = (state_q == FETCH) || (state_q == DISCARD);
    imem_addr = fetch_pc_q;
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clock     (clock),
    .Reset     (Reset),
    .push      (push),
    .push_data ({fetch_pc_q, imem_rdata}),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (fifo_count),
    .head_data (head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign if_valid = !fifo_empty;
  assign if_pc    = head[ENTRY_W-1:INSTR_W];
  assign if_instr = head[INSTR_W-1:0];

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_fetch_d = perf_fetch_q + 32'(push);
    perf_stall_d = perf_stall_q + 32'(state_q == FULL);
  end

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule
